// File: rtl/pdpu_pkg.sv
// Shared types and posit helpers for the PDPU datapath and its chunk accumulator wrapper.
package pdpu_pkg;

    typedef enum logic {StIdle, StRun} acc_state_e;

    // Unpacked posit: fraction is left-aligned below the hidden one.
    typedef struct packed {
        logic               sgn;
        logic               zero;
        logic signed [15:0] scale;
        logic [31:0]        frac;
    } posit_dec_t;

    function automatic logic [31:0] posit_nar(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

    // x holds the n-bit posit left-aligned in 32 bits.
    function automatic posit_dec_t posit_decode(input logic [31:0] x, input int unsigned n,
                                                input int unsigned es);
        posit_dec_t  d;
        logic [31:0] mag;
        logic [31:0] body;
        logic [31:0] rest;
        logic        rb;
        logic        done;
        int          run;
        int          k;
        mag  = x[31] ? -x : x;
        body = mag << 1;
        rb   = body[31];
        run  = 0;
        done = 1'b0;
        for (int i = 0; i < 31; i++) begin
            if (!done && (i < int'(n) - 1) && (body[31-i] == rb)) run++;
            else done = 1'b1;
        end
        k       = rb ? run - 1 : -run;
        rest    = body << (run + 1);
        d.sgn   = x[31];
        d.zero  = (x == '0);
        d.scale = 16'(k * (1 << es) + int'(rest >> (32 - es)));
        d.frac  = rest << es;
        return d;
    endfunction

    // Round-to-nearest-even encode; never rounds to zero or NaR. Result in the low n bits.
    function automatic logic [31:0] posit_encode(input logic sgn, input logic signed [15:0] scale,
                                                 input logic [31:0] frac, input int unsigned n,
                                                 input int unsigned es);
        logic [63:0] lw;
        logic [63:0] ef;
        logic [31:0] body;
        logic [31:0] res;
        logic        guard;
        logic        stk;
        int          k;
        int          len;
        k  = int'(scale) >>> es;
        ef = ((64'(scale) & ((64'd1 << es) - 64'd1)) << (64 - es)) | (64'(frac) << (32 - es));
        if (k >= 0) begin
            lw  = ~(~64'd0 >> (k + 1));
            len = k + 2;
        end else begin
            lw  = 64'h8000_0000_0000_0000 >> (-k);
            len = 1 - k;
        end
        lw    = lw | (ef >> len);
        body  = 32'(lw >> (65 - n));
        guard = lw[64-n];
        stk   = (lw << n) != '0;
        if (guard && (stk || body[0])) body = body + 32'd1;
        if (k > int'(n) - 3) body = (32'd1 << (n - 1)) - 32'd1;
        else if (k < 2 - int'(n)) body = 32'd1;
        res = sgn ? -body : body;
        return res & ((32'd1 << n) - 32'd1);
    endfunction

endpackage

// File: rtl/pdpu_top.sv
// Combinational posit dot product: sum of N products plus acc, aligned to the largest scale
// with ALIGN_WIDTH fraction bits (truncating), rounded once into posit(n_o,es_o).
module pdpu_top
    import pdpu_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned n_i         = 8,
    parameter int unsigned es_i        = 2,
    parameter int unsigned n_o         = 16,
    parameter int unsigned es_o        = 2,
    parameter int unsigned ALIGN_WIDTH = 14
) (
    input  logic [N*n_i-1:0] operands_a_i,
    input  logic [N*n_i-1:0] operands_b_i,
    input  logic [n_o-1:0]   acc_i,
    output logic [n_o-1:0]   result_o
);
    localparam int unsigned MI = n_i - 3 - es_i;
    localparam int unsigned MO = n_o - 3 - es_o;
    localparam int unsigned TW = ALIGN_WIDTH + 2;
    localparam int unsigned SW = TW + $clog2(N + 1) + 1;

    logic signed [15:0]   w_scale [N+1];
    logic                 w_sgn   [N+1];
    logic                 w_zero  [N+1];
    logic [TW-1:0]        w_mag   [N+1];
    logic signed [15:0]   w_emax;
    logic                 w_found;
    logic [SW-1:0]        w_term;
    logic signed [SW-1:0] w_sum;
    logic [SW-1:0]        w_abs;
    int                   w_lead;
    logic [31:0]          w_frac;
    logic signed [15:0]   w_scale_o;
    logic [31:0]          w_res;
    logic                 w_unused_res;

    for (genvar g = 0; g < N; g++) begin : g_prod
        posit_dec_t      w_da;
        posit_dec_t      w_db;
        logic [2*MI+1:0] w_ma;
        logic [2*MI+1:0] w_mb;
        logic [2*MI+1:0] w_pm;
        logic            w_unused_frac;
        assign w_da = posit_decode({operands_a_i[g*n_i +: n_i], {(32-n_i){1'b0}}}, n_i, es_i);
        assign w_db = posit_decode({operands_b_i[g*n_i +: n_i], {(32-n_i){1'b0}}}, n_i, es_i);
        assign w_ma = {{(MI+1){1'b0}}, 1'b1, w_da.frac[31 -: MI]};
        assign w_mb = {{(MI+1){1'b0}}, 1'b1, w_db.frac[31 -: MI]};
        assign w_pm = w_ma * w_mb;
        assign w_sgn[g]   = w_da.sgn ^ w_db.sgn;
        assign w_zero[g]  = w_da.zero || w_db.zero;
        assign w_scale[g] = w_da.scale + w_db.scale;
        assign w_mag[g]   = TW'(w_pm) << (ALIGN_WIDTH - 2 * MI);
        assign w_unused_frac = ^{w_da.frac[31-MI:0], w_db.frac[31-MI:0]};
    end

    posit_dec_t w_dc;
    logic       w_unused_acc;
    assign w_dc       = posit_decode({acc_i, {(32-n_o){1'b0}}}, n_o, es_o);
    assign w_sgn[N]   = w_dc.sgn;
    assign w_zero[N]  = w_dc.zero;
    assign w_scale[N] = w_dc.scale;
    assign w_mag[N]   = TW'({1'b1, w_dc.frac[31 -: MO]}) << (ALIGN_WIDTH - MO);
    assign w_unused_acc = ^w_dc.frac[31-MO:0];

    always_comb begin
        w_emax  = '0;
        w_found = 1'b0;
        for (int i = 0; i <= int'(N); i++) begin
            if (!w_zero[i] && (!w_found || (w_scale[i] > w_emax))) begin
                w_emax  = w_scale[i];
                w_found = 1'b1;
            end
        end
        w_sum  = '0;
        w_term = '0;
        for (int i = 0; i <= int'(N); i++) begin
            if (!w_zero[i]) begin
                w_term = SW'(w_mag[i] >> (w_emax - w_scale[i]));
                w_sum  = w_sgn[i] ? w_sum - $signed(w_term) : w_sum + $signed(w_term);
            end
        end
        w_abs  = w_sum[SW-1] ? SW'(-w_sum) : SW'(w_sum);
        w_lead = 0;
        for (int i = 0; i < int'(SW); i++) begin
            if (w_abs[i]) w_lead = i;
        end
        w_frac    = 32'(w_abs) << (32 - w_lead);
        w_scale_o = w_emax + 16'(w_lead) - 16'(ALIGN_WIDTH);
        w_res     = posit_encode(w_sum[SW-1], w_scale_o, w_frac, n_o, es_o);
        result_o  = (w_sum == '0) ? '0 : w_res[n_o-1:0];
    end

    assign w_unused_res = ^w_res[31:n_o];

endmodule

// File: rtl/pdpu_chunk_acc.sv
// Streams N-element chunks through pdpu_top, keeping the running posit sum in a register.
// Optional PDPU_NAR_STICKY_EN: any NaR input in a dot product forces a NaR result.
module pdpu_chunk_acc
    import pdpu_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned n_i         = 8,
    parameter int unsigned es_i        = 2,
    parameter int unsigned n_o         = 16,
    parameter int unsigned es_o        = 2,
    parameter int unsigned ALIGN_WIDTH = 14,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N*n_i-1:0] operands_a_i,
    input  logic [N*n_i-1:0] operands_b_i,
    input  logic             last_i,
    input  logic [n_o-1:0]   acc_init_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [n_o-1:0]   result_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] chunk_cnt_o
);
    acc_state_e       r_state;
    acc_state_e       w_state_d;
    logic             r_s1_valid;
    logic             r_s1_first;
    logic             r_s1_last;
    logic [N*n_i-1:0] r_s1_a;
    logic [N*n_i-1:0] r_s1_b;
    logic [n_o-1:0]   r_s1_acc_init;
    logic [n_o-1:0]   r_acc;
    logic [n_o-1:0]   r_result;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_cnt;
    logic [n_o-1:0]   w_pdpu_acc;
    logic [n_o-1:0]   w_pdpu_res;
    logic [n_o-1:0]   w_final;
    logic             w_first;
    logic             w_accept;
    logic             w_retire;

    // A last chunk may not retire while an unconsumed result still sits in the output register.
    assign w_retire   = r_s1_valid && !(r_s1_last && r_out_valid && !out_ready_i);
    assign in_ready_o = !r_s1_valid || w_retire;
    assign w_accept   = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= StIdle;
        else       r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        if (w_accept) w_state_d = last_i ? StIdle : StRun;
    end

    always_comb begin
        w_first = (r_state == StIdle);
        busy_o  = (r_state == StRun) || r_s1_valid;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid    <= 1'b0;
            r_s1_first    <= 1'b0;
            r_s1_last     <= 1'b0;
            r_s1_a        <= '0;
            r_s1_b        <= '0;
            r_s1_acc_init <= '0;
            r_acc         <= '0;
            r_result      <= '0;
            r_out_valid   <= 1'b0;
            r_cnt         <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_first <= w_first;
                r_s1_last  <= last_i;
                r_s1_a     <= operands_a_i;
                r_s1_b     <= operands_b_i;
                if (w_first) r_s1_acc_init <= acc_init_i;
                r_cnt <= w_first ? CNT_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));
            end else if (w_retire) begin
                r_s1_valid <= 1'b0;
            end
            if (w_retire) r_acc <= w_pdpu_res;
            if (w_retire && r_s1_last) begin
                r_result    <= w_final;
                r_out_valid <= 1'b1;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign w_pdpu_acc = r_s1_first ? r_s1_acc_init : r_acc;

    pdpu_top #(
        .N          (N),
        .n_i        (n_i),
        .es_i       (es_i),
        .n_o        (n_o),
        .es_o       (es_o),
        .ALIGN_WIDTH(ALIGN_WIDTH)
    ) u_pdpu_top (
        .operands_a_i(r_s1_a),
        .operands_b_i(r_s1_b),
        .acc_i       (w_pdpu_acc),
        .result_o    (w_pdpu_res)
    );

`ifdef PDPU_NAR_STICKY_EN
    logic           r_nar;
    logic           w_nar_in;
    logic [n_i-1:0] w_nar_i;
    logic [n_o-1:0] w_nar_o;
    assign w_nar_i = n_i'(posit_nar(n_i));
    assign w_nar_o = n_o'(posit_nar(n_o));

    always_comb begin
        w_nar_in = w_first && (acc_init_i == w_nar_o);
        for (int i = 0; i < int'(N); i++) begin
            w_nar_in = w_nar_in || (operands_a_i[i*n_i +: n_i] == w_nar_i)
                                || (operands_b_i[i*n_i +: n_i] == w_nar_i);
        end
    end

    // Updated on accept, so at the last chunk's retirement it already covers every chunk.
    always_ff @(posedge clk_i) begin
        if (rst_i)         r_nar <= 1'b0;
        else if (w_accept) r_nar <= w_first ? w_nar_in : (r_nar || w_nar_in);
    end

    assign w_final = r_nar ? w_nar_o : w_pdpu_res;
`else
    assign w_final = w_pdpu_res;
`endif

    assign out_valid_o = r_out_valid;
    assign result_o    = r_result;
    assign chunk_cnt_o = r_cnt;

endmodule

// File: tb/tb_pdpu_chunk_acc.sv
// Directed bench for pdpu_chunk_acc: table of dot products plus backpressure and reset sequences.
// Build with PDPU_NAR_STICKY_EN defined to also exercise the NaR sticky path.
module tb_pdpu_chunk_acc;
    localparam int unsigned N  = 4;
    localparam int unsigned NI = 8;
    localparam int unsigned NO = 16;
    localparam int unsigned CW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*NI-1:0] op_a;
    logic [N*NI-1:0] op_b;
    logic            last;
    logic [NO-1:0]   acc_init;
    logic            out_valid;
    logic            out_ready;
    logic [NO-1:0]   result;
    logic            busy;
    logic [CW-1:0]   cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] acc;
        int          chunks;
        logic [15:0] exp_res;
    } vec_t;

    vec_t vecs[9];

    pdpu_chunk_acc #(
        .N          (N),
        .n_i        (NI),
        .es_i       (2),
        .n_o        (NO),
        .es_o       (2),
        .ALIGN_WIDTH(14),
        .CNT_W      (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .operands_a_i(op_a),
        .operands_b_i(op_b),
        .last_i      (last),
        .acc_init_i  (acc_init),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .busy_o      (busy),
        .chunk_cnt_o (cnt)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Starts and ends on a falling edge with the output register about to drain.
    task automatic run_dp(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] vacc,
                          input int chunks, input logic [15:0] vexp, input bit nar_first);
        int exp_cnt;
        exp_cnt = (chunks > 255) ? 255 : chunks;
        for (int c = 0; c < chunks; c++) begin
            in_valid = 1'b1;
            op_a     = {N{va}};
            op_b     = {N{vb}};
            if (nar_first && (c == 0)) op_a[7:0] = 8'h80;
            last     = (c == chunks - 1);
            acc_init = (c == 0) ? vacc : 16'h7fff;
            #1;
            check("in_ready_stream", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        last     = 1'b0;
        check("out_valid_t1", 32'(out_valid), 32'd0);
        check("busy_t1", 32'(busy), 32'd1);
        @(negedge clk);
        check("out_valid_t2", 32'(out_valid), 32'd1);
        check("result", 32'(result), 32'(vexp));
        check("chunk_cnt", 32'(cnt), 32'(exp_cnt));
        check("busy_done", 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        last      = 1'b0;
        acc_init  = '0;
        out_ready = 1'b1;

        vecs[0] = '{a: 8'h40, b: 8'h40, acc: 16'h0000, chunks: 1,   exp_res: 16'h5000};
        vecs[1] = '{a: 8'h40, b: 8'h40, acc: 16'h0000, chunks: 2,   exp_res: 16'h5800};
        vecs[2] = '{a: 8'h40, b: 8'h40, acc: 16'h0000, chunks: 3,   exp_res: 16'h5c00};
        vecs[3] = '{a: 8'h40, b: 8'h40, acc: 16'h4000, chunks: 1,   exp_res: 16'h5200};
        vecs[4] = '{a: 8'h00, b: 8'h40, acc: 16'h4000, chunks: 1,   exp_res: 16'h4000};
        vecs[5] = '{a: 8'hc0, b: 8'h40, acc: 16'h0000, chunks: 1,   exp_res: 16'hb000};
        vecs[6] = '{a: 8'h48, b: 8'h48, acc: 16'h0000, chunks: 1,   exp_res: 16'h6000};
        vecs[7] = '{a: 8'h40, b: 8'h40, acc: 16'hc000, chunks: 1,   exp_res: 16'h4c00};
        vecs[8] = '{a: 8'h40, b: 8'h40, acc: 16'h0000, chunks: 256, exp_res: 16'h7400};

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_dp(vecs[i].a, vecs[i].b, vecs[i].acc, vecs[i].chunks, vecs[i].exp_res, 1'b0);
        end

        // Backpressure: second result must wait behind the first.
        @(negedge clk);
        check("bp_idle", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op_a      = {N{8'h40}};
        op_b      = {N{8'h40}};
        last      = 1'b1;
        acc_init  = 16'h0000;
        @(negedge clk);
        acc_init = 16'h4000;
        #1;
        check("bp_rdy2", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        last     = 1'b0;
        #1;
        check("bp_stall", 32'(in_ready), 32'd0);
        check("bp_valid1", 32'(out_valid), 32'd1);
        check("bp_res1", 32'(result), 32'h5000);
        @(negedge clk);
        check("bp_hold", 32'(result), 32'h5000);
        check("bp_stall2", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("bp_valid2", 32'(out_valid), 32'd1);
        check("bp_res2", 32'(result), 32'h5200);
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Reset while a dot product is open.
        in_valid = 1'b1;
        last     = 1'b0;
        acc_init = 16'h0000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("run_busy", 32'(busy), 32'd1);
        check("run_cnt", 32'(cnt), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cnt", 32'(cnt), 32'd0);
        rst = 1'b0;
        run_dp(8'h40, 8'h40, 16'h0000, 1, 16'h5000, 1'b0);

`ifdef PDPU_NAR_STICKY_EN
        run_dp(8'h40, 8'h40, 16'h0000, 2, 16'h8000, 1'b1);
        run_dp(8'h40, 8'h40, 16'h0000, 1, 16'h5000, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
